mont_radix4_mul: RTL and testbench
==================================

MONT_RADIX4_MUL -- requirements
Module: mont_radix4_mul

Interface
REQ-001 Parameter WIDTH, default 1024: operand/modulus bit width; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all registers SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 in_a  input  WIDTH  multiplier A, consumed 2 bits per iteration, LSB first.
REQ-006 in_b  input  WIDTH  multiplicand B.
REQ-007 in_b2  input  WIDTH+1  precomputed 2B from the upstream shift/add stage.
REQ-008 in_b3  input  WIDTH+2  precomputed 3B from the upstream shift/add stage.
REQ-009 in_m  input  WIDTH  odd modulus M.
REQ-010 in_m2  input  WIDTH+1  precomputed 2M.
REQ-011 in_m3  input  WIDTH+2  precomputed 3M.
REQ-012 busy  output  1  high from the start-accept edge until done is asserted.
REQ-013 done  output  1  one-cycle pulse when result is valid.
REQ-014 result  output  WIDTH  A*B*2^-WIDTH mod M; held until the next accepted start.

Function
REQ-015 The block SHALL assume M odd, A < M, B < M, and in_b2/in_b3/in_m2/in_m3 exactly 2x/3x of in_b/in_m; behaviour outside these conditions is unspecified but SHALL NOT hang the FSM.
REQ-016 FSM states SHALL be IDLE, ITER, SUB; transitions: IDLE->ITER on start; ITER->SUB after WIDTH/2 iterations; SUB->IDLE always.
REQ-017 On the edge accepting start, all seven operand inputs SHALL be latched, accumulator C cleared, digit counter cleared, busy set.
REQ-018 Operand inputs SHALL be don't-care after the accept edge.
REQ-019 Each ITER edge SHALL process one radix-4 digit a_i = A[2i+1:2i], i = counter.
REQ-020 Per iteration: T = C + a_i*B, with a_i*B selected from {0, B, 2B, 3B}, no multiplier.
REQ-021 Quotient digit q: when M[1:0]=2'b11, q = T[1:0]; when M[1:0]=2'b01, q = (4 - T[1:0]) mod 4.
REQ-022 C_next = (T + q*M) >> 2, with q*M selected from {0, M, 2M, 3M}; the low 2 bits discarded SHALL be zero.
REQ-023 Intermediate T + q*M SHALL be computed at WIDTH+3 bits; C SHALL be stored at WIDTH+1 bits (invariant C < 2M).
REQ-024 Both additions of one iteration SHALL complete in one cycle (chained combinational adders).
REQ-025 SUB edge: result = (C >= M) ? C - M : C[WIDTH-1:0]; done asserted and busy cleared on the same edge.
REQ-026 done SHALL be high for exactly one cycle; result SHALL remain stable until the next accepted start.
REQ-027 Latency: start accepted at edge k -> done high in the cycle following edge k + WIDTH/2 + 1 (513 edges for WIDTH=1024).
REQ-028 start asserted while busy SHALL be ignored, with no effect on the operation in progress.
REQ-029 start asserted in the same cycle that done is high SHALL be accepted (FSM is in IDLE), starting a new operation.
REQ-030 Counter SHALL be log2(WIDTH/2)+1 bits wide; no wrap-around before the ITER->SUB transition.

Reset
REQ-031 reset high SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, result=0, C=0, counter=0.
REQ-032 reset asserted mid-operation SHALL abort it; no done pulse SHALL follow.
REQ-033 After reset deasserts, the first start SHALL begin a clean operation.

Verification
REQ-034 WIDTH=8, M=13, A=5, B=7 (B2=14, B3=21, M2=26, M3=39) -> result=1, done exactly 5 edges after the accept edge.
REQ-035 WIDTH=8, M=11, A=3, B=4 -> result=4 (exercises the M[1:0]=2'b11 quotient path).
REQ-036 WIDTH=8, M=13: A=1, B=1 -> result=3; A=0, B=12 -> result=0.
REQ-037 WIDTH=1024, random odd M with A, B < M and multiples fed from the upstream shift/add stage -> result equals the golden A*B*2^-1024 mod M, done 513 edges after accept; at least 100 vectors.
REQ-038 Reset asserted at iteration 100 -> busy/done/result zero at once; a following start with new operands yields the correct result; start pulses during busy produce no extra done.

Source files
------------

// File: rtl/mont_radix4_mul.sv
// Radix-4 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// Consumes two bits of A per cycle. The digit multiples of B and M come
// precomputed from upstream, so each iteration is a pair of chained adders
// with small 4-way selects and no multiplier.
module mont_radix4_mul #(
    parameter int WIDTH = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_b2,
    input  logic [WIDTH+1:0] in_b3,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH:0]   in_m2,
    input  logic [WIDTH+1:0] in_m3,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = $clog2(HALF) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        SUB
    } state_t;

    // Pick 0, X, 2X or 3X for a radix-4 digit from the precomputed multiples.
    function automatic logic [WIDTH+1:0] sel_multiple(
        input logic [1:0]       d,
        input logic [WIDTH-1:0] x1,
        input logic [WIDTH:0]   x2,
        input logic [WIDTH+1:0] x3
    );
        case (d)
            2'd0:    return '0;
            2'd1:    return {2'b00, x1};
            2'd2:    return {1'b0, x2};
            default: return x3;
        endcase
    endfunction

    // Quotient digit that makes T + q*M divisible by 4. M is odd, so
    // M mod 4 is either 3 (q = T mod 4) or 1 (q = -T mod 4).
    function automatic logic [1:0] quot_digit(
        input logic [1:0] t_lo,
        input logic       m_bit1
    );
        return m_bit1 ? t_lo : (2'b00 - t_lo);
    endfunction

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH:0]     r_b2;
    logic [WIDTH+1:0]   r_b3;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH:0]     r_m2;
    logic [WIDTH+1:0]   r_m3;

    logic [WIDTH:0]     r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;

    logic [WIDTH+1:0]   w_ab;
    logic [WIDTH+2:0]   w_t;
    logic [1:0]         w_q;
    logic [WIDTH+1:0]   w_qm;
    logic [WIDTH+2:0]   w_u;
    logic [WIDTH:0]     w_c_next;
    logic               w_unused_lsbs;
    logic               w_ge;
    logic [WIDTH-1:0]   w_final;

    // One iteration: the low digit of r_a selects the B multiple, then the
    // quotient digit selects the M multiple; both adds chain in one cycle.
    // C < 2M and a_i*B, q*M <= 3M keep T + q*M below 8M, i.e. WIDTH+3 bits.
    assign w_ab     = sel_multiple(r_a[1:0], r_b, r_b2, r_b3);
    assign w_t      = {2'b00, r_c} + {1'b0, w_ab};
    assign w_q      = quot_digit(w_t[1:0], r_m[1]);
    assign w_qm     = sel_multiple(w_q, r_m, r_m2, r_m3);
    assign w_u      = w_t + {1'b0, w_qm};
    assign w_c_next = w_u[WIDTH+2:2];

    // The two bits shifted out are zero by choice of q; nothing consumes them.
    assign w_unused_lsbs = ^w_u[1:0];

    // Final conditional subtraction. C < 2M, so when C >= M the difference
    // fits in WIDTH bits and the low WIDTH bits of C minus M are exact.
    assign w_ge    = (r_c >= {1'b0, r_m});
    assign w_final = w_ge ? (r_c[WIDTH-1:0] - r_m) : r_c[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept start only in IDLE, run HALF iterations, then
    // spend one cycle on the final subtraction.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_next = ITER;
            ITER:    if (r_cnt == LAST_IDX) w_state_next = SUB;
            SUB:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture on accept; A shifts right one digit per iteration so
    // the current digit always sits in r_a[1:0].
    always_ff @(posedge clk) begin
        if (r_state == IDLE && start) begin
            r_a  <= in_a;
            r_b  <= in_b;
            r_b2 <= in_b2;
            r_b3 <= in_b3;
            r_m  <= in_m;
            r_m2 <= in_m2;
            r_m3 <= in_m3;
        end else if (r_state == ITER) begin
            r_a <= {2'b00, r_a[WIDTH-1:2]};
        end
    end

    // Accumulator, digit counter and output flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c      <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_c    <= '0;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                ITER: begin
                    r_c   <= w_c_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                SUB: begin
                    r_result <= w_final;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_mont_radix4_mul.sv
// Bench for mont_radix4_mul: a WIDTH=8 instance for the small directed
// cases and a WIDTH=1024 instance for random vectors, reset abort and
// start-while-busy. Expected results come from a reference that multiplies
// A*B and applies 2^-1 mod M WIDTH times by halving.
module tb_mont_radix4_mul;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic         start8 = 1'b0;
    logic [7:0]   a8 = '0, b8 = '0, m8 = '0;
    logic [8:0]   b2_8 = '0, m2_8 = '0;
    logic [9:0]   b3_8 = '0, m3_8 = '0;
    logic         busy8, done8;
    logic [7:0]   result8;

    // WIDTH=1024 instance
    logic            start1k = 1'b0;
    logic [1023:0]   a1k = '0, b1k = '0, m1k = '0;
    logic [1024:0]   b2_1k = '0, m2_1k = '0;
    logic [1025:0]   b3_1k = '0, m3_1k = '0;
    logic            busy1k, done1k;
    logic [1023:0]   result1k;

    mont_radix4_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8),
        .in_a(a8), .in_b(b8), .in_b2(b2_8), .in_b3(b3_8),
        .in_m(m8), .in_m2(m2_8), .in_m3(m3_8),
        .busy(busy8), .done(done8), .result(result8)
    );

    mont_radix4_mul #(.WIDTH(1024)) dut1k (
        .clk(clk), .reset(reset), .start(start1k),
        .in_a(a1k), .in_b(b1k), .in_b2(b2_1k), .in_b3(b3_1k),
        .in_m(m1k), .in_m2(m2_1k), .in_m3(m3_1k),
        .busy(busy1k), .done(done1k), .result(result1k)
    );

    int n_vec = 0;
    int n_bad = 0;
    int dcnt1k = 0;

    // Count every done pulse of the wide instance.
    always @(posedge clk) begin
        if (done1k) dcnt1k <= dcnt1k + 1;
    end

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h (low 128 bits)", tag, obs[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [1023:0] mont_ref(input logic [1023:0] a, input logic [1023:0] b,
                                               input logic [1023:0] m, input int w);
        logic [2049:0] x;
        logic [2049:0] mm;
        mm = {1026'b0, m};
        x  = {1026'b0, a} * {1026'b0, b};
        for (int i = 0; i < w; i++) begin
            if (x[0]) x = x + mm;
            x = x >> 1;
        end
        x = x % mm;
        return x[1023:0];
    endfunction

    function automatic logic [1023:0] rand_wide();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        a8   = a;
        b8   = b;
        b2_8 = {b, 1'b0};
        b3_8 = {1'b0, b2_8} + {2'b00, b};
        m8   = m;
        m2_8 = {m, 1'b0};
        m3_8 = {1'b0, m2_8} + {2'b00, m};
    endtask

    task automatic drive1k(input logic [1023:0] a, input logic [1023:0] b, input logic [1023:0] m);
        a1k   = a;
        b1k   = b;
        b2_1k = {b, 1'b0};
        b3_1k = {1'b0, b2_1k} + {2'b00, b};
        m1k   = m;
        m2_1k = {m, 1'b0};
        m3_1k = {1'b0, m2_1k} + {2'b00, m};
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] m, input logic [7:0] exp);
        int lat;
        drive8(a, b, m);
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        drive8(8'($urandom()), 8'($urandom()), 8'($urandom()));
        check({tag, " busy"}, busy8, 1);
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, " latency"}, lat, 5);
        check({tag, " result"}, result8, exp);
        check({tag, " busy at done"}, busy8, 0);
    endtask

    task automatic run1k(input string tag, input logic [1023:0] a, input logic [1023:0] b,
                         input logic [1023:0] m, input bit poke);
        int lat;
        logic [1023:0] exp;
        exp = mont_ref(a, b, m, 1024);
        drive1k(a, b, m);
        start1k = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1k = 1'b0;
        drive1k(rand_wide(), rand_wide(), rand_wide());
        check({tag, " busy"}, busy1k, 1);
        lat = 0;
        while (done1k !== 1'b1 && lat < 600) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start1k = poke && (lat == 10 || lat == 200 || lat == 400);
        end
        start1k = 1'b0;
        check({tag, " latency"}, lat, 513);
        check({tag, " result"}, result1k, exp);
        check({tag, " busy at done"}, busy1k, 0);
    endtask

    initial begin
        logic [7:0]    ra8, rb8, rm8;
        logic [1023:0] ra, rb, rm;
        int            dbefore;
        logic [1023:0] held;

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst busy8", busy8, 0);
        check("rst done8", done8, 0);
        check("rst result8", result8, 0);
        check("rst busy1k", busy1k, 0);
        check("rst done1k", done1k, 0);
        check("rst result1k", result1k, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed WIDTH=8 cases, issued back to back so each start lands
        // in the cycle where the previous done is high.
        run8("m13 a1 b1", 8'd1, 8'd1, 8'd13, 8'd3);
        run8("m13 a0 b12", 8'd0, 8'd12, 8'd13, 8'd0);
        run8("m11 a3 b4", 8'd3, 8'd4, 8'd11, 8'd4);
        run8("m13 a5 b7", 8'd5, 8'd7, 8'd13, 8'd1);
        @(posedge clk);
        @(negedge clk);
        check("done8 one cycle", done8, 0);
        repeat (3) @(negedge clk);
        check("result8 held", result8, 1);

        // Random WIDTH=8 vectors, both M mod 4 classes
        for (int i = 0; i < 24; i++) begin
            rm8 = 8'($urandom_range(3, 255)) | 8'd1;
            ra8 = 8'($urandom() % 32'(rm8));
            rb8 = 8'($urandom() % 32'(rm8));
            run8("rand8", ra8, rb8, rm8, mont_ref({1016'b0, ra8}, {1016'b0, rb8}, {1016'b0, rm8}, 8));
            if (i % 3 == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        // Random WIDTH=1024 vectors, a few with start pulses while busy
        dbefore = dcnt1k;
        for (int i = 0; i < 100; i++) begin
            rm = rand_wide();
            rm[1023] = 1'b1;
            rm[0] = 1'b1;
            if (i == 0) begin
                ra = rm - 1;
                rb = rm - 1;
            end else begin
                ra = rand_wide() % rm;
                rb = rand_wide() % rm;
            end
            run1k("rand1k", ra, rb, rm, (i % 25) == 7);
            if (i % 10 == 0) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("done1k count", dcnt1k - dbefore, 100);
        check("done1k one cycle", done1k, 0);

        // Reset during iteration 100 aborts the operation at once
        held = result1k;
        rm = rand_wide();
        rm[1023] = 1'b1;
        rm[0] = 1'b1;
        drive1k(rand_wide() % rm, rand_wide() % rm, rm);
        start1k = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1k = 1'b0;
        repeat (100) @(posedge clk);
        check("pre-reset result", result1k, held);
        #2 reset = 1'b1;
        #1;
        check("abort busy1k", busy1k, 0);
        check("abort done1k", done1k, 0);
        check("abort result1k", result1k, 0);
        check("abort result8", result8, 0);
        dbefore = dcnt1k;
        @(negedge clk);
        reset = 1'b0;
        repeat (530) @(negedge clk);
        check("no done after abort", dcnt1k - dbefore, 0);
        check("idle after abort", busy1k, 0);

        // Clean operation after reset
        rm = rand_wide();
        rm[1023] = 1'b1;
        rm[0] = 1'b1;
        ra = rand_wide() % rm;
        rb = rand_wide() % rm;
        run1k("post-reset", ra, rb, rm, 1'b1);
        repeat (2) @(negedge clk);
        check("post-reset done count", dcnt1k - dbefore, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
